mac_dot_ctrl: RTL and testbench
===============================

Name: mac_dot_ctrl

Overview:
- Sequential controller that drives the combinational 8x8+16 Dadda MAC datapath (ports A, B, C; outputs mult, cout).
- Accepts a stream of unsigned operand pairs and registers them, then feeds each pair to the MAC. The MAC's C input is the block's own accumulator, and each MAC result is written back into that accumulator.
- After LEN products it presents a 16-bit dot product plus a sticky overflow flag on a valid/ready output.
- Sits between the operand source and the result consumer, wrapping one MAC instance.

Parameters:
- LEN, 8, number of products per dot product; legal range 1..255.
- SAT, 1, overflow policy: 1 = saturate to 16'hFFFF on MAC carry-out; 0 = wrap (keep mult).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a dot product; sampled only in IDLE.
- init_acc, input, 16, initial accumulator value; captured with start.
- busy, output, 1, high whenever state is not IDLE.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, operand pair accepted when in_valid and in_ready are both high.
- in_a, input, 8, unsigned multiplicand.
- in_b, input, 8, unsigned multiplier.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, 16, accumulator value (final result in DONE).
- out_ovf, output, 1, sticky flag: any MAC carry-out occurred during this run.
- mac_a, output, 8, to MAC input A (registered operand).
- mac_b, output, 8, to MAC input B (registered operand).
- mac_c, output, 16, to MAC input C (accumulator).
- mac_sum, input, 16, from MAC mult.
- mac_cout, input, 1, from MAC cout.

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronous):
  - state = IDLE; acc, op_a, op_b, op_v, acc_cnt and beat_cnt = 0; ovf = 0.
  - All outputs 0: busy, in_ready, out_valid, out_data, out_ovf, mac_a, mac_b, mac_c.
  - Reset in mid-run discards the run; no partial result is emitted.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - When start = 1: acc <= init_acc, ovf <= 0, both counters <= 0, go to RUN.
- RUN, stage 1 (operand capture):
  - in_ready = (acc_cnt < LEN). It is a function of state/counter only, never of in_valid.
  - On accept: op_a <= in_a, op_b <= in_b, op_v <= 1, acc_cnt++. Otherwise op_v <= 0.
- RUN, stage 2 (accumulate):
  - mac_a = op_a, mac_b = op_b, mac_c = acc, all continuously driven from registers.
  - When op_v = 1 at the edge:
    - acc <= (SAT && mac_cout) ? 16'hFFFF : mac_sum.
    - ovf <= ovf | mac_cout.
    - beat_cnt++.
  - When the accumulate performed has beat_cnt == LEN-1, state <= DONE in the same edge.
- Latency:
  - Start sampled at edge E0. Pairs accepted at E1..ELEN with in_valid held high.
  - out_valid is high after edge E(LEN+1).
  - Input gaps add cycles one-for-one.
- DONE:
  - out_valid = 1, out_data = acc, out_ovf = ovf. All three are held stable until out_ready.
  - in_ready = 0; start is ignored.
  - On out_valid & out_ready: go to IDLE; out_valid is 0 in the next cycle.
  - out_data/out_ovf keep their values in IDLE until the next start.
- Saturated accumulator: stays 16'hFFFF. A zero product produces no cout and leaves ovf unchanged.
- Wrap mode: result is (init_acc + sum of products) mod 2^16; ovf set on any carry.
- Extra input beats after LEN accepts are not consumed (in_ready = 0).
- start asserted while busy: ignored, no state change.
- Arithmetic is unsigned throughout; the MAC computes a*b + c as a 17-bit result {cout, mult}.
- Timing: the MAC path is combinational with gate delays. The bench clock period must be at least 2000 time units so mac_sum/mac_cout settle before each edge.

Test Plan:
- LEN=4, SAT=1, init 0, pairs (1,1), (2,3), (10,10), (255,255), in_valid constant -> out_data 16'hFE6C (65132), out_ovf 0, out_valid 5 cycles after the start edge.
- SAT=1, LEN=4, init 16'hFF00, pairs (16,16), (0,0), (1,1), (2,2) -> out_data 16'hFFFF, out_ovf 1. Same stimulus with SAT=0 -> out_data 16'h0005, out_ovf 1.
- Input gaps: same stimulus as case 1 with in_valid low for 3 cycles between beats, plus a 5th pair presented -> result 16'hFE6C; in_ready falls after the 4th accept and the 5th pair stays unconsumed.
- Output stall: out_ready low for 5 cycles in DONE, with start pulsed -> out_valid/out_data/out_ovf stable, busy 1, start ignored. Raise out_ready -> IDLE, out_valid 0 in the next cycle.
- Reset mid-run: after 2 accepted beats, pulse rst_n low between edges -> all outputs 0 immediately. A new run (LEN=4, init 16'h0100, pairs all (1,1)) -> out_data 16'h0104.
- LEN=1 boundary: init 16'h0010, pair (3,5) -> out_data 16'h001F, out_ovf 0, out_valid 2 cycles after the start edge.

Source files
------------

// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - sequential dot-product controller wrapping an external combinational MAC
//
// Purpose:
//   Accepts LEN unsigned 8-bit operand pairs, feeds each registered pair to an
//   external MAC (a*b + c) whose C input is the local accumulator, writes each
//   MAC result back, and presents the 16-bit dot product plus a sticky carry
//   flag on a valid/ready output.
//
// Parameters:
//   LEN  products per dot product (1..255)
//   SAT  1 = saturate accumulator to 16'hFFFF on MAC carry-out, 0 = wrap
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, init_acc       begin a run (IDLE only), initial accumulator value
//   busy                  state is not IDLE
//   in_valid/in_ready     operand handshake; in_a, in_b operands
//   out_valid/out_ready   result handshake; out_data accumulator, out_ovf sticky carry
//   mac_a, mac_b, mac_c   registered operands and accumulator to the MAC
//   mac_sum, mac_cout     MAC result {cout, mult}

module mac_dot_ctrl #(
  parameter int unsigned LEN = 8,
  parameter bit          SAT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] init_acc,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  output logic [15:0] mac_c,
  input  logic [15:0] mac_sum,
  input  logic        mac_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LEN_C  = 8'(LEN);
  localparam logic [7:0] LAST_C = 8'(LEN - 1);

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic        op_v_q, op_v_d;
  logic [7:0]  acc_cnt_q, acc_cnt_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_v_q     <= 1'b0;
      acc_cnt_q  <= '0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_v_q     <= op_v_d;
      acc_cnt_q  <= acc_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Ready depends only on state and the accept count, so the source can
  // present extra beats without them being swallowed after LEN accepts.
  assign in_ready  = (state_q == S_RUN) && (acc_cnt_q < LEN_C);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign mac_a     = op_a_q;
  assign mac_b     = op_b_q;
  assign mac_c     = acc_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_v_d     = 1'b0;
    acc_cnt_d  = acc_cnt_q;
    beat_cnt_d = beat_cnt_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          acc_d      = init_acc;
          ovf_d      = 1'b0;
          acc_cnt_d  = '0;
          beat_cnt_d = '0;
        end
      end

      S_RUN: begin
        // Stage 1: capture the next operand pair.
        if (in_valid && in_ready) begin
          op_a_d    = in_a;
          op_b_d    = in_b;
          op_v_d    = 1'b1;
          acc_cnt_d = acc_cnt_q + 8'd1;
        end
        // Stage 2: fold the pair captured last cycle into the accumulator.
        if (op_v_q) begin
          acc_d      = (SAT && mac_cout) ? 16'hFFFF : mac_sum;
          ovf_d      = ovf_q | mac_cout;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == LAST_C) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb/tb_mac_dot_ctrl.sv - scoreboard bench for mac_dot_ctrl with a behavioural MAC

`timescale 1ns/1ps

module tb_mac_dot_ctrl;

  typedef struct {
    logic [15:0] d;
    logic        o;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_m = 1'b0, start_w = 1'b0, start_1 = 1'b0;
  logic [15:0] init_acc = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        out_ready = 1'b1;

  // main: LEN=4 SAT=1, wrap: LEN=4 SAT=0, one: LEN=1 SAT=1
  logic        busy_m, in_ready_m, out_valid_m, out_ovf_m, cout_m;
  logic [15:0] out_data_m, mac_c_m, sum_m;
  logic [7:0]  mac_a_m, mac_b_m;
  logic        busy_w, in_ready_w, out_valid_w, out_ovf_w, cout_w;
  logic [15:0] out_data_w, mac_c_w, sum_w;
  logic [7:0]  mac_a_w, mac_b_w;
  logic        busy_1, in_ready_1, out_valid_1, out_ovf_1, cout_1;
  logic [15:0] out_data_1, mac_c_1, sum_1;
  logic [7:0]  mac_a_1, mac_b_1;

  logic [7:0] pa [0:7];
  logic [7:0] pb [0:7];
  exp_t sb_m[$], sb_w[$], sb_1[$];

  always #1000 clk = ~clk;

  assign {cout_m, sum_m} = {9'd0, mac_a_m} * {9'd0, mac_b_m} + {1'b0, mac_c_m};
  assign {cout_w, sum_w} = {9'd0, mac_a_w} * {9'd0, mac_b_w} + {1'b0, mac_c_w};
  assign {cout_1, sum_1} = {9'd0, mac_a_1} * {9'd0, mac_b_1} + {1'b0, mac_c_1};

  mac_dot_ctrl #(.LEN(4), .SAT(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .init_acc(init_acc), .busy(busy_m),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m), .out_ovf(out_ovf_m),
    .mac_a(mac_a_m), .mac_b(mac_b_m), .mac_c(mac_c_m), .mac_sum(sum_m), .mac_cout(cout_m));

  mac_dot_ctrl #(.LEN(4), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .init_acc(init_acc), .busy(busy_w),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .out_ovf(out_ovf_w),
    .mac_a(mac_a_w), .mac_b(mac_b_w), .mac_c(mac_c_w), .mac_sum(sum_w), .mac_cout(cout_w));

  mac_dot_ctrl #(.LEN(1), .SAT(1'b1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .init_acc(init_acc), .busy(busy_1),
    .in_valid(in_valid), .in_ready(in_ready_1), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1), .out_ovf(out_ovf_1),
    .mac_a(mac_a_1), .mac_b(mac_b_1), .mac_c(mac_c_1), .mac_sum(sum_1), .mac_cout(cout_1));

  function automatic exp_t model(input logic [15:0] init, input int n, input bit sat);
    exp_t e;
    logic [16:0] s;
    e.d = init;
    e.o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = 17'(pa[i]) * 17'(pb[i]) + 17'(e.d);
      if (s[16]) e.o = 1'b1;
      e.d = (sat && s[16]) ? 16'hFFFF : s[15:0];
    end
    return e;
  endfunction

  task automatic set_pairs(input logic [7:0] a0, b0, a1, b1, a2, b2, a3, b3);
    pa[0] = a0; pb[0] = b0; pa[1] = a1; pb[1] = b1;
    pa[2] = a2; pb[2] = b2; pa[3] = a3; pb[3] = b3;
  endtask

  // Pulses start for one edge (E0); returns at the negedge after E0.
  task automatic do_start(input bit m, input bit w, input bit one, input logic [15:0] init);
    @(negedge clk);
    start_m = m; start_w = w; start_1 = one; init_acc = init;
    @(negedge clk);
    start_m = 1'b0; start_w = 1'b0; start_1 = 1'b0;
  endtask

  // Feeds n pairs, idle gap cycles between beats; sel 1 = LEN=1 instance.
  task automatic feed(input int n, input int gap, input int sel);
    int idx = 0;
    int gcnt = 0;
    int guard = 0;
    logic fire;
    while (idx < n && guard < 200) begin
      if (gcnt > 0) begin
        in_valid = 1'b0;
        gcnt--;
      end else begin
        in_valid = 1'b1;
        in_a = pa[idx];
        in_b = pb[idx];
      end
      fire = in_valid && ((sel == 1) ? in_ready_1 : in_ready_m);
      @(negedge clk);
      guard++;
      if (fire) begin
        idx++;
        gcnt = gap;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL feed_timeout accepted %0d required %0d", idx, n);
    end
  endtask

  task automatic wait_out(input int sel);
    int guard = 0;
    while (((sel == 1) ? out_valid_1 : out_valid_m) !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL out_valid_timeout sel %0d", sel);
    end
  endtask

  task automatic pop_check(input string name, input int sel, input logic [15:0] d, input logic o);
    exp_t e;
    checks++;
    if ((sel == 0 && sb_m.size() == 0) || (sel == 1 && sb_1.size() == 0) ||
        (sel == 2 && sb_w.size() == 0)) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = (sel == 0) ? sb_m.pop_front() : (sel == 1) ? sb_1.pop_front() : sb_w.pop_front();
      if (d !== e.d || o !== e.o) begin
        errors++;
        $display("FAIL %s got data %h ovf %b expected data %h ovf %b", name, d, o, e.d, e.o);
      end
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({busy_m, in_ready_m, out_valid_m, out_ovf_m, out_data_m, mac_a_m, mac_b_m, mac_c_m} !== '0 ||
        {busy_w, out_valid_w, out_data_w, busy_1, out_valid_1, out_data_1} !== '0) begin
      errors++;
      $display("FAIL %s got busy %b rdy %b vld %b ovf %b data %h a %h b %h c %h expected all 0",
               name, busy_m, in_ready_m, out_valid_m, out_ovf_m, out_data_m, mac_a_m, mac_b_m, mac_c_m);
    end
  endtask

  task automatic test_reset();
    #10;
    check_idle_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset_release");
  endtask

  task automatic test_basic();
    set_pairs(8'd1, 8'd1, 8'd2, 8'd3, 8'd10, 8'd10, 8'd255, 8'd255);
    sb_m.push_back(model(16'h0000, 4, 1'b1));
    do_start(1'b1, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (busy_m !== 1'b1 || in_ready_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_run_entry got busy %b rdy %b expected 1 1", busy_m, in_ready_m);
    end
    feed(4, 0, 0);
    checks++;
    if (out_valid_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early out_valid %b expected 0 after E4", out_valid_m);
    end
    @(negedge clk);
    checks++;
    if (out_valid_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency out_valid %b expected 1 after E5", out_valid_m);
    end
    pop_check("basic_result", 0, out_data_m, out_ovf_m);
    @(negedge clk);
    checks++;
    if (out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle got vld %b busy %b expected 0 0", out_valid_m, busy_m);
    end
  endtask

  task automatic test_sat_wrap();
    set_pairs(8'd16, 8'd16, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2);
    sb_m.push_back(model(16'hFF00, 4, 1'b1));
    sb_w.push_back(model(16'hFF00, 4, 1'b0));
    do_start(1'b1, 1'b1, 1'b0, 16'hFF00);
    feed(4, 0, 0);
    wait_out(0);
    pop_check("sat_result", 0, out_data_m, out_ovf_m);
    checks++;
    if (out_valid_w !== 1'b1) begin
      errors++;
      $display("FAIL wrap_valid got %b expected 1", out_valid_w);
    end
    pop_check("wrap_result", 2, out_data_w, out_ovf_w);
    @(negedge clk);
  endtask

  task automatic test_gaps();
    set_pairs(8'd1, 8'd1, 8'd2, 8'd3, 8'd10, 8'd10, 8'd255, 8'd255);
    pa[4] = 8'd77; pb[4] = 8'd99;
    sb_m.push_back(model(16'h0000, 4, 1'b1));
    do_start(1'b1, 1'b0, 1'b0, 16'h0000);
    feed(4, 3, 0);
    // Present a 5th pair; it must not be consumed.
    in_valid = 1'b1;
    in_a = pa[4];
    in_b = pb[4];
    checks++;
    if (in_ready_m !== 1'b0) begin
      errors++;
      $display("FAIL gaps_ready_drop in_ready %b expected 0 after 4th accept", in_ready_m);
    end
    wait_out(0);
    pop_check("gaps_result", 0, out_data_m, out_ovf_m);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    exp_t e;
    set_pairs(8'd3, 8'd7, 8'd200, 8'd100, 8'd255, 8'd255, 8'd9, 8'd9);
    e = model(16'h1234, 4, 1'b1);
    sb_m.push_back(e);
    out_ready = 1'b0;
    do_start(1'b1, 1'b0, 1'b0, 16'h1234);
    feed(4, 0, 0);
    wait_out(0);
    for (int i = 0; i < 5; i++) begin
      start_m = (i == 2);
      checks++;
      if (out_valid_m !== 1'b1 || busy_m !== 1'b1 || out_data_m !== e.d || out_ovf_m !== e.o) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got vld %b busy %b data %h ovf %b expected 1 1 %h %b",
                 i, out_valid_m, busy_m, out_data_m, out_ovf_m, e.d, e.o);
      end
      @(negedge clk);
    end
    start_m = 1'b0;
    pop_check("stall_result", 0, out_data_m, out_ovf_m);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || out_data_m !== e.d || out_ovf_m !== e.o) begin
      errors++;
      $display("FAIL stall_release got vld %b busy %b data %h ovf %b expected 0 0 %h %b",
               out_valid_m, busy_m, out_data_m, out_ovf_m, e.d, e.o);
    end
    @(negedge clk);
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL stall_start_ignored busy %b expected 0", busy_m);
    end
  endtask

  task automatic test_reset_midrun();
    set_pairs(8'd50, 8'd60, 8'd70, 8'd80, 8'd1, 8'd1, 8'd1, 8'd1);
    do_start(1'b1, 1'b1, 1'b0, 16'h4321);
    feed(2, 0, 0);
    #100;
    rst_n = 1'b0;
    #10;
    check_idle_zero("reset_midrun_async");
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_partial got vld %b busy %b expected 0 0", out_valid_m, busy_m);
      end
    end
    set_pairs(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    sb_m.push_back(model(16'h0100, 4, 1'b1));
    do_start(1'b1, 1'b0, 1'b0, 16'h0100);
    feed(4, 0, 0);
    wait_out(0);
    pop_check("reset_rerun_result", 0, out_data_m, out_ovf_m);
    @(negedge clk);
  endtask

  task automatic test_len1();
    pa[0] = 8'd3; pb[0] = 8'd5;
    sb_1.push_back(model(16'h0010, 1, 1'b1));
    do_start(1'b0, 1'b0, 1'b1, 16'h0010);
    feed(1, 0, 1);
    checks++;
    if (out_valid_1 !== 1'b0 || in_ready_1 !== 1'b0) begin
      errors++;
      $display("FAIL len1_early got vld %b rdy %b expected 0 0 after E1", out_valid_1, in_ready_1);
    end
    @(negedge clk);
    checks++;
    if (out_valid_1 !== 1'b1) begin
      errors++;
      $display("FAIL len1_latency out_valid %b expected 1 after E2", out_valid_1);
    end
    pop_check("len1_result", 1, out_data_1, out_ovf_1);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat_wrap();
    test_gaps();
    test_stall();
    test_reset_midrun();
    test_len1();
    checks++;
    if (sb_m.size() != 0 || sb_w.size() != 0 || sb_1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d %0d %0d expected 0 0 0",
               sb_m.size(), sb_w.size(), sb_1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
